// File: rtl/trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture_ctrl
// Captures pre/post-trigger ADC history in a circular RAM, then streams the
//   frame out oldest-first over a valid/ready port.
// Revision : 1.0
// ============================================================================
module trigger_capture_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     adc,
  input  logic                  trig_condition,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DEPTH_LOG2-1:0] pre_len,
  input  logic [DEPTH_LOG2:0]   total_len,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic [2:0]            state,
  output logic                  done
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_N = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_N   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] TWO_N   = (DEPTH_LOG2+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t st;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_addr, fill, pre_q, pre_eff;
  logic [DEPTH_LOG2:0]   total_q, total_eff, post_cnt, post_init, rd_cnt;
  logic                  we, rd_fire;

  always_comb begin
    total_eff = (total_len == '0 || total_len > DEPTH_N) ? DEPTH_N : total_len;
    pre_eff   = ({1'b0, pre_len} >= total_eff) ? DEPTH_LOG2'(total_eff - ONE_N) : pre_len;
    post_init = total_q - {1'b0, pre_q} - ONE_N;
  end

  assign we      = (st == S_PRE) || (st == S_ARMED) || (st == S_POST);
  assign rd_fire = rd_valid & rd_ready;
  // Look ahead on a handshake so the sync RAM output always holds the word on display.
  assign rd_addr = rd_fire ? rd_ptr + 1'b1 : rd_ptr;
  assign state   = st;

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= adc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            rd_data <= '0;
    else if (st == S_READ) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      pre_q    <= '0;
      total_q  <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        st       <= S_IDLE;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (arm) begin
              wr_ptr  <= '0;
              fill    <= '0;
              pre_q   <= pre_eff;
              total_q <= total_eff;
              st      <= (pre_eff != '0) ? S_PRE : S_ARMED;
            end
          end
          S_PRE: begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill + 1'b1;
            if (fill == pre_q - 1'b1) st <= S_ARMED;
          end
          S_ARMED: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trig_condition) begin
              rd_ptr   <= wr_ptr - pre_q;
              rd_cnt   <= '0;
              post_cnt <= post_init;
              st       <= (post_init == '0) ? S_READ : S_POST;
            end
          end
          S_POST: begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == ONE_N) st <= S_READ;
          end
          S_READ: begin
            if (!rd_valid) begin
              rd_valid <= 1'b1;
              rd_last  <= (total_q == ONE_N);
            end else if (rd_ready) begin
              if (rd_last) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                done     <= 1'b1;
                st       <= S_IDLE;
              end else begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
                rd_last <= (rd_cnt + TWO_N == total_q);
              end
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture_ctrl.sv
`default_nettype none
// Bench for trigger_capture_ctrl: counter-driven ADC, expected frames queued at trigger.
module tb_trigger_capture_ctrl;
  localparam int DW = 16;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc;
  logic          trig_condition, arm, abort, rd_ready;
  logic [DL-1:0] pre_len;
  logic [DL:0]   total_len;
  logic          rd_valid, rd_last, done;
  logic [DW-1:0] rd_data;
  logic [2:0]    state;

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  trigger_capture_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .adc(adc), .trig_condition(trig_condition),
    .arm(arm), .abort(abort), .pre_len(pre_len), .total_len(total_len),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    adc = '0;
    forever begin
      @(posedge clk);
      #1 adc = adc + 1'b1;
    end
  end

  task automatic push_frame(input logic [DW-1:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'(k == n-1), 16'(first + k)});
  endtask

  task automatic do_arm(input int pre, input int total);
    @(negedge clk);
    arm = 1'b1; pre_len = DL'(pre); total_len = (DL+1)'(total);
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic trig_pulse(input int pre, input int total);
    logic [DW-1:0] t;
    @(negedge clk);
    trig_condition = 1'b1;
    t = adc;
    push_frame(16'(t - pre), total);
    @(negedge clk);
    trig_condition = 1'b0;
  endtask

  task automatic read_frame(input bit rnd);
    int guard = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [DW:0] e;
    while (exp_q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   rd_valid, rd_data, rd_last, pd, pl);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL early_done: done=%b required 0", done);
      end
      if (rd_valid && rd_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({rd_last, rd_data} !== e) begin
          failures++;
          $display("FAIL frame_word: last=%b data=%h required last=%b data=%h",
                   rd_last, rd_data, e[DW], e[DW-1:0]);
        end
      end
      pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
    end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL read_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || state !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_end: done=%b state=%0d valid=%b required 1/0/0", done, state, rd_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; trig_condition = 0; arm = 0; abort = 0; rd_ready = 0;
    pre_len = '0; total_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || rd_valid !== 0 || rd_last !== 0 || rd_data !== '0 || done !== 0) begin
      failures++;
      $display("FAIL reset_state: state=%0d valid=%b last=%b data=%h done=%b required all 0",
               state, rd_valid, rd_last, rd_data, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int n = 0;
    do_arm(4, 10);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL state_pre: state=%0d required 1", state); end
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL state_armed: state=%0d required 2", state); end
    while (adc !== 16'h001F && n < 100) begin @(negedge clk); n++; end
    trig_pulse(4, 10);
    checks++;
    if (exp_q[0][DW-1:0] !== 16'h001C) begin
      failures++;
      $display("FAIL trig_align: first=%h required 001c", exp_q[0][DW-1:0]);
    end
    read_frame(1'b0);
  endtask

  task automatic test_trig_in_pre;
    logic [DW-1:0] x;
    @(negedge clk);
    arm = 1'b1; trig_condition = 1'b1; pre_len = 4'd3; total_len = 5'd5;
    x = adc;
    push_frame(16'(x + 1), 5);
    @(negedge clk);
    arm = 1'b0;
    repeat (6) @(negedge clk);
    trig_condition = 1'b0;
    read_frame(1'b0);
  endtask

  task automatic test_wrap;
    do_arm(0, 0);
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL pre0_armed: state=%0d required 2", state); end
    repeat (40) @(negedge clk);
    trig_pulse(0, 16);
    read_frame(1'b0);
  endtask

  task automatic test_random_ready;
    do_arm(5, 12);
    repeat (8) @(negedge clk);
    trig_pulse(5, 12);
    read_frame(1'b1);
  endtask

  task automatic test_abort;
    int bad = 0;
    do_arm(2, 10);
    repeat (5) @(negedge clk);
    trig_pulse(2, 10);
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL state_post: state=%0d required 3", state); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (state !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: state=%0d valid=%b required 0/0", state, rd_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_quiet: %0d active cycles required 0", bad); end
    @(negedge clk);
    arm = 1'b1; abort = 1'b1; pre_len = 4'd1; total_len = 5'd3;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL arm_abort: state=%0d required 0", state); end
    do_arm(1, 3);
    repeat (3) @(negedge clk);
    trig_pulse(1, 3);
    read_frame(1'b0);
  endtask

  task automatic test_reset_mid_read;
    int n = 0;
    do_arm(2, 8);
    repeat (4) @(negedge clk);
    trig_pulse(2, 8);
    exp_q.delete();
    rd_ready = 1'b0;
    while (rd_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL read_start: valid=%b required 1", rd_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || rd_valid !== 0 || rd_last !== 0 || rd_data !== '0 || done !== 0) begin
      failures++;
      $display("FAIL async_reset: state=%0d valid=%b last=%b data=%h done=%b required all 0",
               state, rd_valid, rd_last, rd_data, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trig_in_pre();
    test_wrap();
    test_random_ready();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
